// File: rtl/oc8051_cxrom_fetch_pkg.sv
// Shared definitions for the oc8051 code-ROM fetch front end:
// bus widths, default parameters, FSM state encoding, prefetch entry payload
// and the sequential-address helper.
package oc8051_cxrom_fetch_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned PF_STRIDE_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2,
    S_PF   = 2'd3
  } fetch_state_e;

  // One prefetched ROM word together with the address it was read from
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pf_entry_t;

  // Sequential successor address, wrapping modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input int unsigned       stride);
    return ADDR_W'(a + ADDR_W'(stride));
  endfunction

endpackage

// File: rtl/oc8051_cxrom_pfbuf.sv
// One-entry prefetch buffer.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   load_i        - capture load_entry_i and mark valid (wins over inval_i)
//   inval_i       - clear the valid flag
//   load_entry_i  - address/data pair to store
//   cmp_addr_i    - address compared against the stored entry
//   hit_c         - combinational: entry valid and address matches
//   pf_data_o     - stored data word
module oc8051_cxrom_pfbuf
  import oc8051_cxrom_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inval_i,
  input  pf_entry_t         load_entry_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic              hit_c,
  output logic [DATA_W-1:0] pf_data_o
);

  logic      pf_valid_q, pf_valid_d;
  pf_entry_t pf_entry_q, pf_entry_d;

  // Next-entry selection
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_entry_d = pf_entry_q;
    if (inval_i) begin
      pf_valid_d = 1'b0;
    end
    if (load_i) begin
      pf_valid_d = 1'b1;
      pf_entry_d = load_entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pf_valid_q <= 1'b0;
      pf_entry_q <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_entry_q <= pf_entry_d;
    end
  end

  assign hit_c     = pf_valid_q && (pf_entry_q.addr == cmp_addr_i);
  assign pf_data_o = pf_entry_q.data;

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// Registered instruction-fetch front end between the oc8051 instruction
// Wishbone port and a combinational code ROM, with a one-word sequential
// prefetch buffer and saturating hit/miss counters.
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   wbi_cyc_i/stb_i/adr_i - core fetch request
//   wbi_dat_o, wbi_ack_o  - fetched word and single-cycle acknowledge
//   cxrom_addr            - registered ROM address
//   cxrom_data_in         - ROM data for cxrom_addr (combinational ROM)
//   hit_cnt, miss_cnt     - saturating prefetch hit / miss counts
module oc8051_cxrom_fetch
  import oc8051_cxrom_fetch_pkg::*;
#(
  parameter int unsigned PF_STRIDE = PF_STRIDE_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbi_cyc_i,
  input  logic              wbi_stb_i,
  input  logic [ADDR_W-1:0] wbi_adr_i,
  output logic [DATA_W-1:0] wbi_dat_o,
  output logic              wbi_ack_o,
  output logic [ADDR_W-1:0] cxrom_addr,
  input  logic [DATA_W-1:0] cxrom_data_in,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  fetch_state_e      state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [ADDR_W-1:0] cxrom_addr_q, cxrom_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              req_c;
  logic              pf_load_c;
  logic              pf_inval_c;
  logic              pf_hit_c;
  logic [DATA_W-1:0] pf_data;

  assign req_c = wbi_cyc_i & wbi_stb_i;

  oc8051_cxrom_pfbuf u_pfbuf (
    .clk          (clk),
    .rst          (rst),
    .load_i       (pf_load_c),
    .inval_i      (pf_inval_c),
    .load_entry_i ('{addr: cxrom_addr_q, data: cxrom_data_in}),
    .cmp_addr_i   (wbi_adr_i),
    .hit_c        (pf_hit_c),
    .pf_data_o    (pf_data)
  );

  // Next-state, datapath and counter updates
  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    dat_d        = dat_q;
    cxrom_addr_d = cxrom_addr_q;
    req_addr_d   = req_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    pf_load_c    = 1'b0;
    pf_inval_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          req_addr_d = wbi_adr_i;
          if (pf_hit_c) begin
            dat_d   = pf_data;
            ack_d   = 1'b1;
            state_d = S_RESP;
            if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            cxrom_addr_d = wbi_adr_i;
            state_d      = S_READ;
            if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      S_READ: begin
        if (!wbi_cyc_i) begin
          // Abandoned fetch: nothing in the buffer may be trusted afterwards
          pf_inval_c = 1'b1;
          state_d    = S_IDLE;
        end else begin
          dat_d   = cxrom_data_in;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        pf_inval_c = 1'b1;
        if (!wbi_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          cxrom_addr_d = next_addr(req_addr_q, PF_STRIDE);
          state_d      = S_PF;
        end
      end
      S_PF: begin
        pf_load_c = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      cxrom_addr_q <= '0;
      req_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      cxrom_addr_q <= cxrom_addr_d;
      req_addr_q   <= req_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Registered ack, masked so that a dropped cycle or an asserted reset
  // during the response cycle never produces an acknowledge
  assign wbi_ack_o  = ack_q & wbi_cyc_i & rst;
  assign wbi_dat_o  = dat_q;
  assign cxrom_addr = cxrom_addr_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Self-checking bench for oc8051_cxrom_fetch: reset values, a directed
// vector table, abort / reset-in-response sequences, counter saturation and
// a randomized fetch stream checked against a transaction-level model.
module tb_oc8051_cxrom_fetch;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           cyc, stb;
  logic [15:0]    adr;
  logic [31:0]    dat;
  logic           ack;
  logic [15:0]    cxrom_addr;
  logic [31:0]    rom_data;
  logic [CW-1:0]  hit_cnt, miss_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level model of the prefetch buffer and counters
  bit          m_pf_valid;
  logic [15:0] m_pf_addr;
  int          m_hits, m_misses;
  bit          m_in_pf;   // bench is sitting in the cycle right after an ack

  typedef struct {
    logic [15:0] addr;
    int          gap;
    bit          hit;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  assign rom_data = {16'hA5A5, cxrom_addr};

  oc8051_cxrom_fetch #(.PF_STRIDE(4), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wbi_cyc_i     (cyc),
    .wbi_stb_i     (stb),
    .wbi_adr_i     (adr),
    .wbi_dat_o     (dat),
    .wbi_ack_o     (ack),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (rom_data),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pf_valid = 1'b0;
    m_pf_addr  = 16'h0000;
    m_hits     = 0;
    m_misses   = 0;
    m_in_pf    = 1'b0;
  endtask

  // Issue one fetch. gap>=1 is the negedge count since the previous ack;
  // gap==1 raises the request in the prefetch cycle, costing one extra cycle.
  task automatic do_fetch(input logic [15:0] a, input int gap, input bit exp_hit,
                          input int exp_h, input int exp_m);
    int          exp_lat;
    int          lat;
    bit          got;
    logic [15:0] na;
    exp_lat = (exp_hit ? 1 : 2) + ((gap == 1 && m_in_pf) ? 1 : 0);
    na      = a + 16'd4;
    repeat (gap - 1) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (ack) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("rdata", dat, {16'hA5A5, a});
      check("hit_cnt", 32'(hit_cnt), 32'(exp_h));
      check("miss_cnt", 32'(miss_cnt), 32'(exp_m));
    end
    stb = 1'b0;
    adr = 16'($urandom);
    @(negedge clk);
    check("ack_single", 32'(ack), 32'd0);
    check("pf_rom_addr", 32'(cxrom_addr), 32'(na));
    m_pf_valid = 1'b1;
    m_pf_addr  = na;
    m_hits     = exp_h;
    m_misses   = exp_m;
    m_in_pf    = 1'b1;
  endtask

  task automatic fetch_model(input logic [15:0] a, input int gap);
    bit h;
    h = m_pf_valid && (m_pf_addr == a);
    do_fetch(a, gap, h, h ? sat(m_hits + 1) : m_hits, h ? m_misses : sat(m_misses + 1));
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] y;
    logic [15:0] a;

    tbl[0] = '{16'h0100, 2, 1'b0, 0, 1};
    tbl[1] = '{16'h0104, 2, 1'b1, 1, 1};
    tbl[2] = '{16'h0200, 2, 1'b0, 1, 2};
    tbl[3] = '{16'h0204, 3, 1'b1, 2, 2};
    tbl[4] = '{16'hFFFC, 2, 1'b0, 2, 3};
    tbl[5] = '{16'h0000, 2, 1'b1, 3, 3};
    tbl[6] = '{16'h0004, 1, 1'b1, 4, 3};
    tbl[7] = '{16'h0100, 1, 1'b0, 4, 4};

    // Reset with random bus activity
    rst = 1'b0;
    cyc = 1'($urandom); stb = 1'($urandom); adr = 16'($urandom);
    repeat (2) begin
      @(negedge clk);
      cyc = 1'($urandom); stb = 1'($urandom); adr = 16'($urandom);
    end
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_rom_addr", 32'(cxrom_addr), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    model_reset();
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      do_fetch(tbl[i].addr, tbl[i].gap, tbl[i].hit, tbl[i].hits, tbl[i].misses);
    end

    // Abort in READ: no ack, buffer invalidated
    p = m_pf_addr;
    y = 16'h3000;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = y;
    @(negedge clk);
    check("abort_read_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    cyc = 1'b1;
    #1;
    check("abort_no_ack", 32'(ack), 32'd0);
    check("abort_miss_cnt", 32'(miss_cnt), 32'(sat(m_misses + 1)));
    m_misses   = sat(m_misses + 1);
    m_pf_valid = 1'b0;
    m_in_pf    = 1'b0;
    @(negedge clk);
    do_fetch(p, 1, 1'b0, m_hits, sat(m_misses + 1));
    fetch_model(y, 1);

    // Reset asserted during the response cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = m_pf_addr;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("rst_resp_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_resp_miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_resp_rom_addr", 32'(cxrom_addr), 32'd0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    model_reset();
    fetch_model(16'h1000, 1);

    // Hit counter saturation
    for (int i = 0; i < 20; i++) begin
      fetch_model(m_pf_addr, 1 + int'($urandom_range(1)));
    end
    check("hit_cnt_sat", 32'(hit_cnt), 32'(CNT_MAX));

    // Randomized stream, mostly sequential
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) < 7) a = m_pf_addr;
      else                       a = 16'($urandom) & 16'hFFFC;
      fetch_model(a, 1 + int'($urandom_range(2)));
    end
    check("miss_cnt_final", 32'(miss_cnt), 32'(m_misses));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
